// File: rtl/pulse_burst_controller_pkg.sv
// pulse_burst_controller_pkg: shared FSM state encoding and default field widths
package pulse_burst_controller_pkg;

    localparam int DEF_CNT_W = 8;
    localparam int DEF_NUM_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/pulse_burst_controller_start_edge_detect.sv
// start_edge_detect: rising-edge decoder for the start level, history cleared by reset
module start_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic start_edge
);

    logic start_d;

    // start history, updated every cycle regardless of controller state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            start_d <= 1'b0;
        else
            start_d <= start;
    end

    assign start_edge = start & ~start_d;

endmodule

// File: rtl/pulse_burst_controller.sv
// pulse_burst_controller: generates a burst of programmable high/low pulses on a start edge
module pulse_burst_controller
    import pulse_burst_controller_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int NUM_W = DEF_NUM_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] high_cycles,
    input  logic [CNT_W-1:0] low_cycles,
    input  logic [NUM_W-1:0] pulse_count,
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] pulses_sent
);

    state_t           state, state_next;
    logic             start_edge, accept, phase_end, last_pulse;
    logic             pulse_next, busy_next, done_next;
    logic [CNT_W-1:0] phase_cnt, phase_cnt_next;
    logic [CNT_W-1:0] high_len, high_len_next, low_len, low_len_next;
    logic [NUM_W-1:0] pulses_left, pulses_left_next, pulses_sent_next;

    function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    start_edge_detect u_edge (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_edge (start_edge)
    );

    // abort in the same idle cycle discards the edge
    assign accept     = (state == IDLE) && start_edge && !abort;
    assign phase_end  = phase_cnt <= CNT_W'(1);
    assign last_pulse = pulses_left <= NUM_W'(1);

    // state, counters, latched configuration and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            phase_cnt   <= '0;
            pulses_left <= '0;
            high_len    <= '0;
            low_len     <= '0;
            pulses_sent <= '0;
            pulse_out   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_next;
            phase_cnt   <= phase_cnt_next;
            pulses_left <= pulses_left_next;
            high_len    <= high_len_next;
            low_len     <= low_len_next;
            pulses_sent <= pulses_sent_next;
            pulse_out   <= pulse_next;
            busy        <= busy_next;
            done        <= done_next;
        end
    end

    // next-state: a zero-count burst never leaves IDLE, abort always returns to IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = (accept && pulse_count != '0) ? HIGH : IDLE;
            HIGH:    state_next = abort ? IDLE : !phase_end ? HIGH : last_pulse ? IDLE : LOW;
            LOW:     state_next = abort ? IDLE : phase_end ? HIGH : LOW;
            default: state_next = IDLE;
        endcase
    end

    // datapath and output values to be registered alongside the next state
    always_comb begin
        phase_cnt_next   = phase_cnt;
        pulses_left_next = pulses_left;
        high_len_next    = high_len;
        low_len_next     = low_len;
        pulses_sent_next = pulses_sent;
        done_next        = 1'b0;
        if (accept) begin
            high_len_next    = high_cycles;
            low_len_next     = low_cycles;
            pulses_left_next = pulse_count;
            pulses_sent_next = '0;
            phase_cnt_next   = at_least_one(high_cycles);
            done_next        = (pulse_count == '0);
        end else if (state != IDLE && !abort) begin
            if (!phase_end) begin
                phase_cnt_next = phase_cnt - CNT_W'(1);
            end else if (state == HIGH) begin
                pulses_sent_next = pulses_sent + NUM_W'(1);
                pulses_left_next = pulses_left - NUM_W'(1);
                done_next        = last_pulse;
                phase_cnt_next   = at_least_one(low_len);
            end else begin
                phase_cnt_next = at_least_one(high_len);
            end
        end
        pulse_next = (state_next == HIGH);
        busy_next  = (state_next != IDLE);
    end

endmodule

// File: tb/tb_pulse_burst_controller.sv
// tb_pulse_burst_controller: directed checks of burst waveforms, abort, reset and limits
module tb_pulse_burst_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] high_cycles = '0;
    logic [7:0] low_cycles = '0;
    logic [7:0] pulse_count = '0;
    logic       pulse_out, busy, done;
    logic [7:0] pulses_sent;
    int         total = 0;
    int         bad = 0;
    int         n;

    pulse_burst_controller dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .high_cycles (high_cycles),
        .low_cycles  (low_cycles),
        .pulse_count (pulse_count),
        .pulse_out   (pulse_out),
        .busy        (busy),
        .done        (done),
        .pulses_sent (pulses_sent)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // pat bit i-1 is the expected pulse_out in cycle i after the accepting edge
    task automatic burst(input string tag, input logic [7:0] h, input logic [7:0] l,
                         input logic [7:0] c, input int cycles, input logic [15:0] pat,
                         input int blen, input int dcyc, input logic [7:0] sent,
                         input bit disturb);
        high_cycles = h;
        low_cycles  = l;
        pulse_count = c;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 1; i <= cycles; i++) begin
            if (disturb && i == 3) begin
                start = 1'b1;
                high_cycles = 8'd7;
                low_cycles = 8'd1;
                pulse_count = 8'd9;
            end
            if (disturb && i == 5) start = 1'b0;
            chk($sformatf("%s_pulse_c%0d", tag, i), pulse_out, pat[i-1]);
            chk($sformatf("%s_busy_c%0d", tag, i), busy, i <= blen);
            chk($sformatf("%s_done_c%0d", tag, i), done, i == dcyc);
            tick;
        end
        chk({tag, "_sent"}, pulses_sent, sent);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        tick;
        chk("rst_pulse", pulse_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sent", pulses_sent, 0);
        #3 rst_n = 1'b1;
        tick;
        chk("idle_busy", busy, 0);

        // h=3 l=2 c=2: 1,1,1,0,0,1,1,1 then done in cycle 9
        burst("basic", 8'd3, 8'd2, 8'd2, 9, 16'h00E7, 8, 9, 8'd2, 1'b0);
        tick;
        chk("basic_hold_sent", pulses_sent, 2);
        chk("basic_hold_done", done, 0);

        // zero lengths act as one cycle
        burst("zero_len", 8'd0, 8'd0, 8'd3, 6, 16'h0015, 5, 6, 8'd3, 1'b0);

        // zero pulse count: done strobe only
        burst("zero_cnt", 8'd3, 8'd3, 8'd0, 3, 16'h0000, 0, 1, 8'd0, 1'b0);

        // second edge and config change mid-burst leave the waveform untouched
        burst("disturb", 8'd3, 8'd2, 8'd2, 9, 16'h00E7, 8, 9, 8'd2, 1'b1);

        // abort in the 2nd cycle of the first gap
        high_cycles = 8'd4;
        low_cycles = 8'd4;
        pulse_count = 8'd5;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (5) tick;
        chk("abort_pre_pulse", pulse_out, 0);
        chk("abort_pre_busy", busy, 1);
        chk("abort_pre_sent", pulses_sent, 1);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_pulse", pulse_out, 0);
        chk("abort_done", done, 0);
        chk("abort_sent", pulses_sent, 1);
        tick;
        chk("abort_after_done", done, 0);
        chk("abort_after_busy", busy, 0);

        // abort wins over a simultaneous idle edge, and the edge is not remembered
        high_cycles = 8'd2;
        pulse_count = 8'd1;
        start = 1'b1;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort_edge_busy", busy, 0);
        chk("abort_edge_done", done, 0);
        tick;
        chk("abort_edge_later_busy", busy, 0);
        chk("abort_edge_sent", pulses_sent, 1);
        start = 1'b0;
        tick;

        // maximum pulse count with minimal phases: 255 high + 254 low cycles
        high_cycles = 8'd0;
        low_cycles = 8'd0;
        pulse_count = 8'd255;
        start = 1'b1;
        tick;
        start = 1'b0;
        n = 0;
        while (busy && n < 2000) begin
            n++;
            tick;
        end
        chk("max_cnt_len", n, 509);
        chk("max_cnt_done", done, 1);
        chk("max_cnt_sent", pulses_sent, 255);

        // maximum phase length
        high_cycles = 8'd255;
        pulse_count = 8'd1;
        start = 1'b1;
        tick;
        start = 1'b0;
        n = 0;
        while (busy && n < 2000) begin
            n++;
            tick;
        end
        chk("max_len_len", n, 255);
        chk("max_len_done", done, 1);
        chk("max_len_sent", pulses_sent, 1);

        // reset mid-HIGH, start held through release counts as an edge
        high_cycles = 8'd5;
        low_cycles = 8'd1;
        pulse_count = 8'd2;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        chk("pre_rst_pulse", pulse_out, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_pulse", pulse_out, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_sent", pulses_sent, 0);
        high_cycles = 8'd1;
        low_cycles = 8'd1;
        pulse_count = 8'd1;
        start = 1'b1;
        tick;
        chk("in_rst_busy", busy, 0);
        chk("in_rst_done", done, 0);
        #3 rst_n = 1'b1;
        tick;
        chk("post_rst_pulse", pulse_out, 1);
        chk("post_rst_busy", busy, 1);
        start = 1'b0;
        tick;
        chk("post_rst_end_pulse", pulse_out, 0);
        chk("post_rst_end_busy", busy, 0);
        chk("post_rst_end_done", done, 1);
        chk("post_rst_sent", pulses_sent, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
